// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// The entry struct describes one {pc, instr} pair as it leaves the queue toward decode.
package fetch_queue_pkg;

   localparam int FQ_ADDR_WIDTH  = 32;
   localparam int FQ_INSTR_WIDTH = 32;
   localparam logic [FQ_INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [FQ_ADDR_WIDTH-1:0]  pc;
      logic [FQ_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   // Pointer width for a power-of-two queue depth, never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the program counter, instruction memory, the fetch queue and decode.
// The master modport is the fetch queue's view of the bundle; slave is the environment's view.
interface fetch_queue_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]  pc_i;
   logic                   pc_advance_o;
   logic                   redirect_i;
   logic [ADDR_WIDTH-1:0]  imem_addr_o;
   logic [INSTR_WIDTH-1:0] imem_rdata_i;
   logic                   instr_valid_o;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [ADDR_WIDTH-1:0]  instr_pc_o;
   logic                   instr_ready_i;

   modport master (
      input  pc_i, redirect_i, imem_rdata_i, instr_ready_i,
      output pc_advance_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );

   modport slave (
      output pc_i, redirect_i, imem_rdata_i, instr_ready_i,
      input  pc_advance_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Small circular buffer of fetched {pc, instr} words with push, pop and a whole-queue flush.
// The head word is read combinationally from storage; it is meaningless while count is zero.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   input  logic                           flush,
   output logic [WIDTH-1:0]               head_data,
   output logic [ptr_width(DEPTH):0]      count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two; flush drops everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_data = storage[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues the PC to a synchronous instruction memory, tags the returned word with
// its PC, and queues the pair for decode, holding the PC whenever no queue slot is free.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int ADDR_WIDTH  = FQ_ADDR_WIDTH,
   parameter int INSTR_WIDTH = FQ_INSTR_WIDTH,
   parameter int DEPTH       = 4
) (
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.master bus
);

   localparam int CW = ptr_width(DEPTH) + 1;
   localparam int UW = CW + 1;
   localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

   logic                  inflight;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic [CW-1:0]         count;
   logic [UW-1:0]         used;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic [EW-1:0]         head;

   // A slot is reserved at issue time, so a word coming back from memory always has room.
   always_comb begin
      used  = UW'(count) + UW'(inflight);
      issue = !rst && !bus.redirect_i && (used < UW'(DEPTH));
      push  = inflight && !bus.redirect_i;
      pop   = bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i;
   end

   // The in-flight bit and its PC tag follow the memory's one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight    <= issue;
         inflight_pc <= bus.pc_i;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({inflight_pc, bus.imem_rdata_i}),
      .pop       (pop),
      .flush     (bus.redirect_i),
      .head_data (head),
      .count     (count)
   );

   assign bus.pc_advance_o  = issue;
   assign bus.imem_addr_o   = rst ? '0 : bus.pc_i;
   assign bus.instr_valid_o = (count != '0);
   assign bus.instr_pc_o    = head[EW-1 -: ADDR_WIDTH];
   assign bus.instr_o       = head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a PC/memory environment drives the queue while a monitor
// scoreboards every word handed to decode against the PC that was issued for it.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_rdata_q;
   logic [31:0] cur_pc;
   logic        last_adv;
   int          checks;
   int          errors;
   int          pops_seen;
   int          adv_count;
   fetch_entry_t exp_q [$];

   fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

   fetch_queue #(
      .ADDR_WIDTH  (32),
      .INSTR_WIDTH (32),
      .DEPTH       (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: word at byte address a is 0xA + a/4.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_000A + (a >> 2);
   endfunction

   // Synchronous instruction memory: data returns one cycle after the address.
   always @(posedge clk) imem_rdata_q <= mem_word(bus.imem_addr_o);
   assign bus.imem_rdata_i = imem_rdata_q;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] pc,
                                input logic rdy);
      rst               = r;
      bus.redirect_i    = redir;
      cur_pc            = pc;
      bus.pc_i          = pc;
      bus.instr_ready_i = rdy;
      #1;
   endtask

   // One clock: the upstream PC steps by 4 after every edge at which a fetch was issued.
   task automatic runCycle();
      @(negedge clk);
      last_adv = bus.pc_advance_o;
      @(posedge clk);
      #2;
      if (last_adv) cur_pc = cur_pc + 32'd4;
      bus.pc_i = cur_pc;
      #1;
   endtask

   // Scoreboard: issues push the expected pair, handshakes pop and compare, flushes clear.
   always @(negedge clk) begin
      if (rst || bus.redirect_i) begin
         exp_q.delete();
      end else begin
         if (bus.instr_valid_o && bus.instr_ready_i) begin
            checks++;
            pops_seen++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_unexpected: got pc 0x%0h instr 0x%0h expected no entry",
                        bus.instr_pc_o, bus.instr_o);
            end else begin
               fetch_entry_t e;
               e = exp_q.pop_front();
               if (bus.instr_pc_o !== e.pc || bus.instr_o !== e.instr) begin
                  errors++;
                  $display("[TB] FAIL sb_entry: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                           bus.instr_pc_o, bus.instr_o, e.pc, e.instr);
               end
            end
         end
         if (bus.pc_advance_o) begin
            fetch_entry_t n;
            n.pc    = bus.pc_i;
            n.instr = mem_word(bus.pc_i);
            exp_q.push_back(n);
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      pops_seen = 0;
      last_adv  = 1'b0;

      // Held in reset: nothing issued, nothing presented, all outputs zero.
      applyStimulus(1'b1, 1'b0, 32'h40, 1'b1);
      for (int i = 0; i < 3; i++) begin
         runCycle();
         checkOutput("rst_adv", bus.pc_advance_o, 0);
         checkOutput("rst_valid", bus.instr_valid_o, 0);
      end
      checkOutput("rst_instr", bus.instr_o, 0);
      checkOutput("rst_instr_pc", bus.instr_pc_o, 0);
      checkOutput("rst_imem_addr", bus.imem_addr_o, 0);

      // Straight-line fetch with decode always ready.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("imem_addr_follow", bus.imem_addr_o, 32'h0);
      runCycle();
      checkOutput("lat_valid_early", bus.instr_valid_o, 0);
      runCycle();
      checkOutput("head0_valid", bus.instr_valid_o, 1);
      checkOutput("head0_pc", bus.instr_pc_o, 32'h0);
      checkOutput("head0_instr", bus.instr_o, 32'hA);
      runCycle();
      checkOutput("head1_pc", bus.instr_pc_o, 32'h4);
      checkOutput("head1_instr", bus.instr_o, 32'hB);
      runCycle();
      checkOutput("head2_pc", bus.instr_pc_o, 32'h8);
      checkOutput("head2_instr", bus.instr_o, 32'hC);

      // Decode stalled from an empty queue: exactly DEPTH fetches, then the PC holds.
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
      runCycle();
      applyStimulus(1'b0, 1'b0, 32'h200, 1'b0);
      adv_count = 0;
      for (int i = 0; i < 8; i++) begin
         runCycle();
         if (last_adv) adv_count++;
      end
      checkOutput("fill_issues", adv_count, 4);
      checkOutput("full_adv", bus.pc_advance_o, 0);
      checkOutput("full_head_pc", bus.instr_pc_o, 32'h200);

      // One pop frees exactly one credit, spent on exactly one new fetch.
      applyStimulus(1'b0, 1'b0, cur_pc, 1'b1);
      runCycle();
      checkOutput("pop_cycle_adv", last_adv, 0);
      applyStimulus(1'b0, 1'b0, cur_pc, 1'b0);
      adv_count = 0;
      for (int i = 0; i < 4; i++) begin
         runCycle();
         if (last_adv) adv_count++;
      end
      checkOutput("refill_issues", adv_count, 1);
      checkOutput("after_pop_head_pc", bus.instr_pc_o, 32'h204);

      // Draining a full queue with simultaneous push/pop keeps order and reaches steady issue.
      applyStimulus(1'b0, 1'b0, cur_pc, 1'b1);
      for (int i = 0; i < 6; i++) runCycle();
      checkOutput("steady_adv", bus.pc_advance_o, 1);
      checkOutput("steady_valid", bus.instr_valid_o, 1);

      // Three queued plus one in flight, then a redirect flushes all of it.
      applyStimulus(1'b0, 1'b0, cur_pc, 1'b0);
      runCycle();
      checkOutput("pre_redirect_adv", bus.pc_advance_o, 0);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
      checkOutput("redirect_no_issue", bus.pc_advance_o, 0);
      runCycle();
      checkOutput("flush_valid", bus.instr_valid_o, 0);
      applyStimulus(1'b0, 1'b0, 32'h100, 1'b1);
      checkOutput("target_issue", bus.pc_advance_o, 1);
      runCycle();
      checkOutput("target_valid_early", bus.instr_valid_o, 0);
      runCycle();
      checkOutput("target_valid", bus.instr_valid_o, 1);
      checkOutput("target_pc", bus.instr_pc_o, 32'h100);
      checkOutput("target_instr", bus.instr_o, 32'h4A);

      // Back-to-back redirects: nothing from any earlier target may surface.
      applyStimulus(1'b0, 1'b1, 32'h180, 1'b1);
      runCycle();
      applyStimulus(1'b0, 1'b1, 32'h1C0, 1'b1);
      runCycle();
      checkOutput("b2b_valid", bus.instr_valid_o, 0);
      applyStimulus(1'b0, 1'b1, 32'h2C0, 1'b1);
      runCycle();
      applyStimulus(1'b0, 1'b0, 32'h2C0, 1'b1);
      runCycle();
      checkOutput("b2b_valid_early", bus.instr_valid_o, 0);
      runCycle();
      checkOutput("b2b_pc", bus.instr_pc_o, 32'h2C0);
      checkOutput("b2b_instr", bus.instr_o, 32'hBA);

      // Asynchronous reset mid-stream with entries queued.
      applyStimulus(1'b0, 1'b0, cur_pc, 1'b0);
      runCycle();
      checkOutput("prereset_valid", bus.instr_valid_o, 1);
      applyStimulus(1'b1, 1'b0, cur_pc, 1'b0);
      checkOutput("async_valid", bus.instr_valid_o, 0);
      checkOutput("async_adv", bus.pc_advance_o, 0);
      checkOutput("async_instr_pc", bus.instr_pc_o, 0);
      runCycle();
      applyStimulus(1'b0, 1'b0, 32'h300, 1'b1);
      runCycle();
      checkOutput("post_rst_valid_early", bus.instr_valid_o, 0);
      runCycle();
      checkOutput("post_rst_pc", bus.instr_pc_o, 32'h300);
      checkOutput("post_rst_instr", bus.instr_o, 32'hCA);

      for (int i = 0; i < 6; i++) runCycle();
      checkOutput("sb_activity", (pops_seen > 10), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
